// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath.
// Steps each instruction through fetch, decode, execute, an optional memory
// phase and write-back. Every datapath select and enable is derived from the
// latched instruction register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | program memory read; ir captures instr at the end of the cycle
// DECODE  | opcode classified; selects become valid
// EXECUTE | ALU operands stable; branch condition captured into taken
// MEM     | data memory access; waits on dm_ready with a timeout
// WB      | register write-back and PC update (one cycle)
// TRAP    | illegal opcode or memory timeout; held until reset
module rv32i_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RAM_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RAM_WIDTH-1:0] instr,
  input  logic                 br_eq,
  input  logic                 br_lt,
  input  logic                 br_ltu,
  input  logic                 dm_ready,
  output logic [RAM_WIDTH-1:0] ir,
  output logic                 pc_en,
  output logic [1:0]           selpc,
  output logic [1:0]           WBSEL,
  output logic [1:0]           op1_sel,
  output logic [1:0]           op2_sel,
  output logic [1:0]           imm_sel,
  output logic [3:0]           alu_ctrl,
  output logic                 reg_write_en,
  output logic                 dm_enable,
  output logic                 dm_write_enable,
  output logic                 illegal,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Last counter value before a missing dm_ready becomes a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       taken_q;
  logic [7:0] wait_cnt_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt_bit;
  logic       rd_nz;
  logic       is_branch, is_load, is_store, writes_rd, opcode_legal, branch_f3_ok;
  logic       branch_cond, sel_active;
  logic [3:0] alu_arith;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign alt_bit = ir[30];
  assign rd_nz   = |ir[11:7];

  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign writes_rd = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                     (opcode == OPC_JALR) || is_load || (opcode == OPC_OPIMM) ||
                     (opcode == OPC_OP);
  assign opcode_legal = writes_rd || is_branch || is_store;
  assign branch_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
  assign sel_active   = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                        (state_q == S_MEM) || (state_q == S_WB);
  assign state        = state_q;

  // Branch condition from the datapath comparator flags.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      3'b000:  branch_cond = br_eq;
      3'b001:  branch_cond = !br_eq;
      3'b100:  branch_cond = br_lt;
      3'b101:  branch_cond = !br_lt;
      3'b110:  branch_cond = br_ltu;
      3'b111:  branch_cond = !br_ltu;
      default: branch_cond = 1'b0;
    endcase
  end

  // ALU function for OP / OP-IMM; ir[30] selects SUB (OP only) and SRA/SRAI.
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000:  alu_arith = ((opcode == OPC_OP) && alt_bit) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_arith = ALU_SLL;
      3'b010:  alu_arith = ALU_SLT;
      3'b011:  alu_arith = ALU_SLTU;
      3'b100:  alu_arith = ALU_XOR;
      3'b101:  alu_arith = alt_bit ? ALU_SRA : ALU_SRL;
      3'b110:  alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = opcode_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_branch && !branch_f3_ok) state_d = S_TRAP;
        else if (is_load || is_store)   state_d = S_MEM;
        else                            state_d = S_WB;
      end
      S_MEM: begin
        if (dm_ready)                      state_d = S_WB;
        else if (wait_cnt_q == WAIT_LAST)  state_d = S_TRAP;
      end
      S_WB:      state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  // Datapath selects and enables, decoded from ir and the current state.
  always_comb begin
    selpc           = 2'b00;
    WBSEL           = 2'b00;
    op1_sel         = 2'b00;
    op2_sel         = 2'b00;
    imm_sel         = 2'b00;
    alu_ctrl        = ALU_ADD;
    pc_en           = (state_q == S_WB);
    reg_write_en    = (state_q == S_WB) && writes_rd && rd_nz;
    dm_enable       = (state_q == S_MEM);
    dm_write_enable = (state_q == S_MEM) && is_store;
    if (sel_active) begin
      case (opcode)
        OPC_LUI:    begin selpc = 2'b11; WBSEL = 2'b11; op1_sel = 2'b01; op2_sel = 2'b01; end
        OPC_AUIPC:  begin selpc = 2'b11; WBSEL = 2'b10; op1_sel = 2'b00; op2_sel = 2'b01; end
        OPC_JAL:    begin selpc = 2'b01; WBSEL = 2'b00; op1_sel = 2'b00; op2_sel = 2'b10; imm_sel = 2'b11; end
        OPC_JALR:   begin selpc = 2'b00; WBSEL = 2'b00; op1_sel = 2'b10; op2_sel = 2'b10; end
        OPC_BRANCH: begin
          selpc   = taken_q ? 2'b10 : 2'b11;
          WBSEL   = 2'b10;
          op1_sel = 2'b00;
          op2_sel = 2'b10;
          imm_sel = 2'b11;
        end
        OPC_LOAD:   begin selpc = 2'b11; WBSEL = 2'b01; op1_sel = 2'b10; op2_sel = 2'b10; end
        OPC_STORE:  begin selpc = 2'b11; WBSEL = 2'b10; op1_sel = 2'b10; op2_sel = 2'b10; imm_sel = 2'b10; end
        OPC_OPIMM:  begin
          selpc    = 2'b11;
          WBSEL    = 2'b10;
          op1_sel  = 2'b10;
          op2_sel  = 2'b10;
          imm_sel  = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? 2'b01 : 2'b00;
          alu_ctrl = alu_arith;
        end
        OPC_OP:     begin
          selpc    = 2'b11;
          WBSEL    = 2'b10;
          op1_sel  = 2'b10;
          op2_sel  = 2'b00;
          alu_ctrl = alu_arith;
        end
        default: ;
      endcase
    end
  end

  // Instruction register captures program memory output at the end of FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 ir <= '0;
    else if (state_q == S_FETCH) ir <= instr;
  end

  // Branch outcome is captured in EXECUTE so WB sees a stable selpc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  taken_q <= 1'b0;
    else if ((state_q == S_EXECUTE) && is_branch) taken_q <= branch_cond;
  end

  // Memory wait counter; cleared on completion so each access starts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_q <= '0;
    else if (state_q == S_MEM) begin
      if (dm_ready) wait_cnt_q <= '0;
      else          wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Sticky trap flag, set on the transition into TRAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  illegal <= 1'b0;
    else if (state_d == S_TRAP)  illegal <= 1'b1;
  end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Scoreboard bench for rv32i_ctrl_fsm: stimulus pushes the expected
// write-back or trap response, a monitor pops it when the FSM reaches WB or
// TRAP and compares selects, enables, latency and memory-phase length.
module tb_rv32i_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        br_eq, br_lt, br_ltu, dm_ready;
  logic [31:0] ir;
  logic        pc_en;
  logic [1:0]  selpc, WBSEL, op1_sel, op2_sel, imm_sel;
  logic [3:0]  alu_ctrl;
  logic        reg_write_en, dm_enable, dm_write_enable, illegal;
  logic [2:0]  state;

  rv32i_ctrl_fsm #(.MEM_TIMEOUT(15), .RAM_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .br_eq(br_eq), .br_lt(br_lt),
    .br_ltu(br_ltu), .dm_ready(dm_ready), .ir(ir), .pc_en(pc_en), .selpc(selpc),
    .WBSEL(WBSEL), .op1_sel(op1_sel), .op2_sel(op2_sel), .imm_sel(imm_sel),
    .alu_ctrl(alu_ctrl), .reg_write_en(reg_write_en), .dm_enable(dm_enable),
    .dm_write_enable(dm_write_enable), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         trap;
    int         cycles;
    int         mem;
    int         memwe;
    logic [1:0] selpc, wbsel, op1, op2, imm;
    logic [3:0] alu;
    logic       rwe;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, memc = 0, memwec = 0, viol = 0, we_total = 0;
  bit trap_seen = 0;
  int mem_lat = 0, mem_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input bit trap, input int cycles, input int mem,
                              input int memwe, input logic [1:0] sp, input logic [1:0] wb,
                              input logic [1:0] o1, input logic [1:0] o2, input logic [1:0] im,
                              input logic [3:0] alu, input logic rwe);
    exp_t r;
    r.name = n; r.trap = trap; r.cycles = cycles; r.mem = mem; r.memwe = memwe;
    r.selpc = sp; r.wbsel = wb; r.op1 = o1; r.op2 = o2; r.imm = im; r.alu = alu; r.rwe = rwe;
    return r;
  endfunction

  // Data memory model: dm_ready rises after mem_lat wait cycles in MEM.
  always @(negedge clk) begin
    if (state == 3'd3) begin
      mem_seen++;
      dm_ready = (mem_seen > mem_lat);
    end else begin
      mem_seen = 0;
      dm_ready = 1'b0;
    end
  end

  // Monitor: tracks latency and invariants, checks each WB / TRAP response.
  always @(negedge clk) begin
    if (dm_write_enable) we_total++;
    if (pc_en && state != 3'd4) viol++;
    if (reg_write_en && state != 3'd4) viol++;
    if ((dm_enable || dm_write_enable) && state != 3'd3) viol++;
    if (!reset) trap_seen = 0;
    if (!reset || state == 3'd0) begin
      cyc = 1; memc = 0; memwec = 0;
    end else begin
      cyc++;
      if (state == 3'd3) memc++;
      if (dm_write_enable) memwec++;
      if (state == 3'd4 || (state == 3'd7 && !trap_seen)) begin
        if (state == 3'd7) trap_seen = 1;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: state %0d with empty scoreboard", state);
        end else begin
          e = sb.pop_front();
          check({e.name, ":trap_kind"}, {31'd0, state == 3'd7}, {31'd0, e.trap});
          check({e.name, ":cycles"}, cyc, e.cycles);
          check({e.name, ":mem_cycles"}, memc, e.mem);
          check({e.name, ":dm_we_cycles"}, memwec, e.memwe);
          check({e.name, ":invariants"}, viol, 0);
          if (e.trap) begin
            check({e.name, ":illegal"}, {31'd0, illegal}, 1);
            check({e.name, ":pc_en"}, {31'd0, pc_en}, 0);
          end else begin
            check({e.name, ":pc_en"}, {31'd0, pc_en}, 1);
            check({e.name, ":selpc"}, {30'd0, selpc}, {30'd0, e.selpc});
            check({e.name, ":WBSEL"}, {30'd0, WBSEL}, {30'd0, e.wbsel});
            check({e.name, ":op1_sel"}, {30'd0, op1_sel}, {30'd0, e.op1});
            check({e.name, ":op2_sel"}, {30'd0, op2_sel}, {30'd0, e.op2});
            check({e.name, ":imm_sel"}, {30'd0, imm_sel}, {30'd0, e.imm});
            check({e.name, ":alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e.alu});
            check({e.name, ":reg_write_en"}, {31'd0, reg_write_en}, {31'd0, e.rwe});
          end
        end
      end
    end
  end

  task automatic run_vec(input exp_t ex, input logic [31:0] ins, input logic eq,
                         input logic lt, input logic ltu, input int lat);
    reset = 1'b0;
    instr = ins; br_eq = eq; br_lt = lt; br_ltu = ltu; mem_lat = lat;
    @(negedge clk);
    sb.push_back(ex);
    reset = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check({ex.name, ":response_seen"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int pcn;
    reset = 1'b0; instr = 32'h0; br_eq = 0; br_lt = 0; br_ltu = 0; dm_ready = 0;
    #12;
    check("reset_state", {29'd0, state}, 0);
    check("reset_ir", ir, 0);
    check("reset_illegal", {31'd0, illegal}, 0);
    check("reset_enables", {28'd0, pc_en, reg_write_en, dm_enable, dm_write_enable}, 0);
    check("reset_selects", {22'd0, selpc, WBSEL, op1_sel, op2_sel, imm_sel}, 0);

    run_vec(mk("addi_x1", 0, 4, 0, 0, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 4'd0, 1), 32'h00500093, 0, 0, 0, 0);
    run_vec(mk("lw_wait3", 0, 8, 4, 0, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 4'd0, 1), 32'h0000A103, 0, 0, 0, 3);
    run_vec(mk("beq_taken", 0, 4, 0, 0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 4'd0, 0), 32'h00000463, 1, 0, 0, 0);
    run_vec(mk("beq_not", 0, 4, 0, 0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 4'd0, 0), 32'h00000463, 0, 0, 0, 0);
    run_vec(mk("bne_not", 0, 4, 0, 0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 4'd0, 0), 32'h00001463, 1, 0, 0, 0);
    run_vec(mk("blt_taken", 0, 4, 0, 0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 4'd0, 0), 32'h0000C463, 0, 1, 0, 0);
    run_vec(mk("bgeu_taken", 0, 4, 0, 0, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 4'd0, 0), 32'h0000F463, 0, 0, 0, 0);
    run_vec(mk("addi_x0", 0, 4, 0, 0, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 4'd0, 0), 32'h00000013, 0, 0, 0, 0);
    run_vec(mk("sub", 0, 4, 0, 0, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 4'd1, 1), 32'h40208133, 0, 0, 0, 0);
    run_vec(mk("srai", 0, 4, 0, 0, 2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 4'd7, 1), 32'h4040D193, 0, 0, 0, 0);
    run_vec(mk("jal", 0, 4, 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 4'd0, 1), 32'h010000EF, 0, 0, 0, 0);
    run_vec(mk("lui", 0, 4, 0, 0, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 4'd0, 1), 32'h123452B7, 0, 0, 0, 0);
    run_vec(mk("sw_ready_at_limit", 0, 19, 15, 15, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 4'd0, 0), 32'h0020A023, 0, 0, 0, 14);
    run_vec(mk("branch_bad_f3", 1, 4, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 0), 32'h00002463, 0, 0, 0, 0);
    run_vec(mk("sw_timeout", 1, 19, 15, 15, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 0), 32'h0020A023, 0, 0, 0, 1000);

    run_vec(mk("illegal_op", 1, 3, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 0), 32'h00000000, 0, 0, 0, 0);
    pcn = 0;
    repeat (20) begin
      @(negedge clk);
      if (pc_en) pcn++;
    end
    check("trap_pc_en_count", pcn, 0);
    check("trap_hold_state", {29'd0, state}, 7);
    check("trap_illegal_sticky", {31'd0, illegal}, 1);
    reset = 1'b0;
    #1;
    check("trap_reset_illegal", {31'd0, illegal}, 0);
    check("trap_reset_state", {29'd0, state}, 0);

    // Reset asserted while a store is in EXECUTE.
    instr = 32'h0020A023; mem_lat = 0;
    @(negedge clk);
    reset = 1'b1;
    we_total = 0;
    for (int i = 0; i < 10 && state != 3'd2; i++) @(negedge clk);
    check("abort_reach_execute", {29'd0, state}, 2);
    reset = 1'b0;
    #1;
    check("abort_async_state", {29'd0, state}, 0);
    check("abort_dm_we", {31'd0, dm_write_enable}, 0);
    repeat (3) @(negedge clk);
    check("abort_no_store", we_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_ctrl_fsm.md
Name: rv32i_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I processor datapath (PC, program memory, reg_file, ALU, data memory, select muxes). It steps each instruction through FETCH, DECODE, EXECUTE, optional MEM, and WB. It drives every datapath select, enable and ALU control from a latched instruction register. It stalls on the data-memory ready handshake and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting in MEM for dm_ready before trapping (1..255)
RAM_WIDTH, 32, instruction/data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr  input  32  program memory output_data
br_eq  input  1  rs1 == rs2 from datapath comparator
br_lt  input  1  signed rs1 < rs2
br_ltu  input  1  unsigned rs1 < rs2
dm_ready  input  1  data memory access complete
ir  output  32  latched instruction to datapath (register addresses, immediates)
pc_en  output  1  prog_cnt load enable
selpc  output  2  00 jalr target, 01 jal, 10 branch, 11 pc4
WBSEL  output  2  00 pc4, 01 DM_OUT, 10 ALU_OUT, 11 LUI immediate
op1_sel  output  2  00 PC, 01 zero, 10 Reg_data1
op2_sel  output  2  00 Reg_data2, 01 U-imm, 10 Imm_out
imm_sel  output  2  00 I, 01 shamt, 10 S, 11 B/J
alu_ctrl  output  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND
reg_write_en  output  1  reg_file write_en
dm_enable  output  1  data memory ram_enable
dm_write_enable  output  1  data memory write_enable
illegal  output  1  sticky trap flag
state  output  3  current state, debug

Behaviour:
- Reset (reset=0, async): state=FETCH, ir=0, taken=0, wait counter=0, illegal=0. All enables are 0 and selects are 0 while in reset.
- States: FETCH(0), DECODE(1), EXECUTE(2), MEM(3), WB(4), TRAP(7). All transitions occur on the rising clk edge.
- FETCH: one cycle. Program memory is synchronous; at the end of FETCH, ir <= instr. Next state is DECODE.
- DECODE: classify ir[6:0] from this set: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode goes to TRAP.
  - Otherwise next state is EXECUTE. The selects from the following bullets are valid from DECODE onward.
- EXECUTE: ALU operands and alu_ctrl are stable.
  - alu_ctrl decodes from funct3/funct7[5]. SUB and SRA need funct7[5]=1 on OP; SRAI needs ir[30]=1.
  - LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE use ADD.
  - BRANCH: taken <= (funct3 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu). funct3 010/011 goes to TRAP.
  - Next state: LOAD/STORE go to MEM; all others go to WB.
- MEM: dm_enable=1; dm_write_enable=1 for STORE only.
  - While waiting, the counter increments each cycle.
  - dm_ready=1 leads to WB and clears the counter.
  - Counter reaching MEM_TIMEOUT with dm_ready=0 leads to TRAP.
  - dm_ready sampled in the same cycle the counter hits the limit takes priority (no trap).
- WB: exactly one cycle, then FETCH.
  - pc_en=1.
  - reg_write_en=1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP only when ir[11:7]!=0.
  - selpc: JAL 01, JALR 00, BRANCH 10 if taken else 11, all others 11.
  - WBSEL: JAL/JALR 00, LOAD 01, LUI 11, all others 10.
  - op1_sel: AUIPC/JAL/BRANCH 00, LUI 01, all others 10.
  - op2_sel: OP 00, LUI/AUIPC 01, all others 10.
- TRAP: illegal=1; all enables 0; the state holds until reset.
- Latency: non-memory instructions take 4 cycles. Loads/stores take 5 + N cycles, where N is the number of dm_ready=0 cycles in MEM.
- pc_en, reg_write_en, dm_write_enable never assert outside WB/MEM. Each is asserted for at most one instruction per cycle.
- Reset asserted mid-instruction aborts immediately; no partial writes occur after reset is asserted.

Test Plan:
- instr=0x00500093 (ADDI x1,x0,5) after reset release -> states 0,1,2,4. In WB: reg_write_en=1, WBSEL=10, op2_sel=10, alu_ctrl=0, selpc=11, pc_en=1. Total 4 cycles.
- instr=0x0000A103 (LW x2,0(x1)), dm_ready low 3 cycles -> MEM lasts 4 cycles with dm_enable=1, dm_write_enable=0. WB asserts WBSEL=01, reg_write_en=1. Total 8 cycles.
- instr=0x00000463 (BEQ x0,x0,+8), br_eq=1 -> WB selpc=10, reg_write_en=0. Repeat with br_eq=0 -> selpc=11.
- instr=0x00000013 with rd=0 variant (ADDI x0,x0,0) -> reg_write_en stays 0 in WB; pc_en=1.
- instr=0x00000000 -> TRAP after DECODE, illegal=1, pc_en=0 for 20 cycles. Then reset=0 clears illegal and the FSM returns to FETCH.
- STORE 0x0020A023 with dm_ready held 0 -> TRAP after exactly MEM_TIMEOUT=15 MEM cycles. Second run asserting reset=0 in EXECUTE -> state=FETCH asynchronously, dm_write_enable never 1.
